ptp_bridge_dbg_cntr_bank: RTL and testbench

Register bank for the PTP bridge debug event counters. It holds NUM_CNTR live counters and increments each one by one per event through the shared combinational incrementer. It captures all counters atomically into shadow registers on a snapshot command. The shadow copies are exposed to software over a 32-bit Avalon-MM CSR slave, which sits between the bridge's event-pulse sources and the debug CSR fabric.

---
 rtl/ptp_bridge_dbg_pkg.sv | 19 +
 rtl/ptp_bridge_dbg_cntr.sv | 20 ++
 rtl/ptp_bridge_dbg_cntr_bank.sv | 112 +++++++++++
 tb/tb_ptp_bridge_dbg_cntr_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_bridge_dbg_pkg.sv
// Shared constants for the PTP bridge debug counter bank: CSR map, CTRL bits
// and the decoded CTRL command type.
package ptp_bridge_dbg_pkg;

    localparam int CSR_DATA_W     = 32;

    localparam int CTRL_ADDR      = 0;
    localparam int OVF_ADDR       = 1;
    localparam int CNTR_BASE_ADDR = 2;

    localparam int SNAP_BIT       = 0;
    localparam int CLR_BIT        = 1;

    typedef struct packed {
        logic snap;
        logic clr;
    } ctrl_cmd_t;

endpackage

// File: rtl/ptp_bridge_dbg_cntr.sv
// Shared combinational incrementer: each lane adds its enable bit to its count,
// wrapping naturally at 2^CNTR_WIDTH.
module ptp_bridge_dbg_cntr
    import ptp_bridge_dbg_pkg::*;
#(
    parameter int CNTR_WIDTH = 32,
    parameter int NUM_CNTR   = 8
) (
    input  logic [NUM_CNTR-1:0]                 enable,
    input  logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_i,
    output logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_o
);

    always_comb begin
        for (int n = 0; n < NUM_CNTR; n++) begin
            cntr_o[n] = cntr_i[n] + CNTR_WIDTH'(enable[n]);
        end
    end

endmodule

// File: rtl/ptp_bridge_dbg_cntr_bank.sv
// Debug event counter bank: live counters with sticky overflow, atomic
// snapshot into shadows, and a 1-cycle-latency Avalon-MM CSR read path.
module ptp_bridge_dbg_cntr_bank
    import ptp_bridge_dbg_pkg::*;
#(
    parameter int CNTR_WIDTH = 32,
    parameter int NUM_CNTR   = 8,
    parameter int CSR_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CNTR-1:0]   event_i,
    input  logic [CSR_ADDR_W-1:0] csr_address,
    input  logic                  csr_write,
    input  logic [CSR_DATA_W-1:0] csr_writedata,
    input  logic                  csr_read,
    output logic [CSR_DATA_W-1:0] csr_readdata,
    output logic                  csr_readdatavalid
);

    logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] r_cnt;
    logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] r_shd_cnt;
    logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] w_cnt_inc;
    logic [NUM_CNTR-1:0]                 r_ovf;
    logic [NUM_CNTR-1:0]                 r_shd_ovf;
    logic [NUM_CNTR-1:0]                 w_ovf_set;
    ctrl_cmd_t                           w_ctrl;
    logic                                w_ctrl_wr;
    logic                                w_rd_en;
    logic [CSR_DATA_W-1:0]               w_rd_mux;
    logic [CSR_DATA_W-1:0]               r_rdata;
    logic                                r_rvalid;
    logic                                w_unused_wdata;

    ptp_bridge_dbg_cntr #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .NUM_CNTR   (NUM_CNTR)
    ) u_cntr (
        .enable (event_i),
        .cntr_i (r_cnt),
        .cntr_o (w_cnt_inc)
    );

    assign w_ctrl_wr      = csr_write && (csr_address == CSR_ADDR_W'(CTRL_ADDR));
    assign w_ctrl.snap    = w_ctrl_wr && csr_writedata[SNAP_BIT];
    assign w_ctrl.clr     = w_ctrl_wr && csr_writedata[CLR_BIT];
    assign w_unused_wdata = ^csr_writedata[CSR_DATA_W-1:CLR_BIT+1];

    // A write wins over a simultaneous read, which then answers with zero.
    assign w_rd_en = csr_read && !csr_write;

    always_comb begin
        for (int n = 0; n < NUM_CNTR; n++) begin
            w_ovf_set[n] = event_i[n] && (&r_cnt[n]);
        end
    end

    // CLR reloads each counter with its same-cycle event so nothing is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (w_ctrl.clr) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, which is what makes SNAP+CLR atomic.
            for (int n = 0; n < NUM_CNTR; n++) begin
                r_cnt[n] <= CNTR_WIDTH'(event_i[n]);
            end
            r_ovf <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadows are real flops, not RAM, so they are reset and a post-reset read returns 0.
            r_shd_cnt <= '0;
            r_shd_ovf <= '0;
        end else if (w_ctrl.snap) begin
            r_shd_cnt <= r_cnt;
            r_shd_ovf <= r_ovf;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_rd_mux and no latch is inferred.
        w_rd_mux = '0;
        if (csr_address == CSR_ADDR_W'(OVF_ADDR)) begin
            w_rd_mux[NUM_CNTR-1:0] = r_shd_ovf;
        end
        for (int n = 0; n < NUM_CNTR; n++) begin
            if (csr_address == CSR_ADDR_W'(CNTR_BASE_ADDR + n)) begin
                w_rd_mux[CNTR_WIDTH-1:0] = r_shd_cnt[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= csr_read;
            r_rdata  <= w_rd_en ? w_rd_mux : '0;
        end
    end

    assign csr_readdata      = r_rdata;
    assign csr_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_ptp_bridge_dbg_cntr_bank.sv
// Self-checking bench for ptp_bridge_dbg_cntr_bank: an integer-level model
// predicts every read response; directed tests pin literal values.
module tb_ptp_bridge_dbg_cntr_bank;

    localparam int CW   = 4;
    localparam int NC   = 8;
    localparam int AW   = 8;
    localparam int MAXV = 1 << CW;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] event_i;
    logic [AW-1:0] csr_address;
    logic          csr_write;
    logic [31:0]   csr_writedata;
    logic          csr_read;
    logic [31:0]   csr_readdata;
    logic          csr_readdatavalid;

    int total = 0;
    int bad   = 0;

    ptp_bridge_dbg_cntr_bank #(
        .CNTR_WIDTH (CW),
        .NUM_CNTR   (NC),
        .CSR_ADDR_W (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .event_i           (event_i),
        .csr_address       (csr_address),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_read          (csr_read),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer counters, snapshot copies, and the
    // response expected one cycle after each read.
    int   m_cnt [NC];
    bit   m_ovf [NC];
    int   m_shd [NC];
    int   m_shd_ovf;
    bit   exp_valid;
    int   exp_data;

    function automatic int model_lookup(input int addr);
        if (addr == 1) return m_shd_ovf;
        if (addr >= 2 && addr < 2 + NC) return m_shd[addr - 2];
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NC; n++) begin
                m_cnt[n] = 0;
                m_ovf[n] = 0;
                m_shd[n] = 0;
            end
            m_shd_ovf = 0;
            exp_valid = 0;
            exp_data  = 0;
        end else begin
            bit snap;
            bit clr;
            exp_valid = csr_read;
            exp_data  = (csr_read && !csr_write) ? model_lookup(int'(csr_address)) : 0;
            snap = csr_write && csr_address == 0 && csr_writedata[0];
            clr  = csr_write && csr_address == 0 && csr_writedata[1];
            if (snap) begin
                m_shd_ovf = 0;
                for (int n = 0; n < NC; n++) begin
                    m_shd[n] = m_cnt[n];
                    if (m_ovf[n]) m_shd_ovf += (1 << n);
                end
            end
            for (int n = 0; n < NC; n++) begin
                if (clr) begin
                    m_cnt[n] = event_i[n] ? 1 : 0;
                    m_ovf[n] = 0;
                end else if (event_i[n]) begin
                    m_cnt[n] = m_cnt[n] + 1;
                    if (m_cnt[n] == MAXV) begin
                        m_cnt[n] = 0;
                        m_ovf[n] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_rvalid", {31'd0, csr_readdatavalid}, {31'd0, exp_valid});
            check("model_rdata", csr_readdata, exp_data);
        end
    end

    // Drive one cycle of inputs starting just after a falling edge.
    task automatic step(input logic [NC-1:0] ev, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
        event_i       = ev;
        csr_read      = rd;
        csr_write     = wr;
        csr_address   = addr;
        csr_writedata = wd;
        @(negedge clk);
        event_i       = '0;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_address   = '0;
        csr_writedata = '0;
    endtask

    task automatic pulse(input logic [NC-1:0] mask, input int cnt);
        for (int i = 0; i < cnt; i++) step(mask, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic ctrl(input logic [31:0] wd, input logic [NC-1:0] ev);
        step(ev, 1'b0, 1'b1, 8'h00, wd);
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
        step('0, 1'b1, 1'b0, addr, '0);
        check({name, "_valid"}, {31'd0, csr_readdatavalid}, 32'd1);
        check(name, csr_readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        event_i       = '0;
        csr_address   = '0;
        csr_write     = 1'b0;
        csr_writedata = '0;
        csr_read      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, csr_readdatavalid}, 32'd0);
        check("reset_data", csr_readdata, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        read_chk("first_read", 8'h02, 32'd0);

        // Count and read: overlapping events on lanes 0 and 3.
        pulse(8'h09, 2);
        pulse(8'h01, 3);
        ctrl(32'h1, '0);
        read_chk("cnt0", 8'h02, 32'd5);
        check("cnt0_gap", {31'd0, csr_readdatavalid}, 32'd1);
        @(negedge clk);
        check("cnt0_one_cycle", {31'd0, csr_readdatavalid}, 32'd0);
        read_chk("cnt3", 8'h05, 32'd2);
        read_chk("cnt1_zero", 8'h03, 32'd0);

        // Wrap and overflow on a 4-bit counter.
        ctrl(32'h2, '0);
        pulse(8'h02, 17);
        ctrl(32'h1, '0);
        read_chk("wrap_cnt1", 8'h03, 32'd1);
        read_chk("wrap_ovf", 8'h01, 32'h2);
        ctrl(32'h2, '0);
        ctrl(32'h1, '0);
        read_chk("clr_ovf", 8'h01, 32'd0);
        read_chk("clr_cnt1", 8'h03, 32'd0);

        // Snapshot boundary: the event in the SNAP cycle is not captured.
        pulse(8'h04, 9);
        ctrl(32'h1, 8'h04);
        read_chk("snap_edge", 8'h04, 32'd9);
        ctrl(32'h1, '0);
        read_chk("snap_next", 8'h04, 32'd10);

        // SNAP+CLR together with a same-cycle event.
        ctrl(32'h2, '0);
        pulse(8'h01, 7);
        ctrl(32'h3, 8'h01);
        read_chk("snapclr_shd", 8'h02, 32'd7);
        ctrl(32'h1, '0);
        read_chk("snapclr_live", 8'h02, 32'd1);
        read_chk("snapclr_cnt2", 8'h04, 32'd0);

        // CSR edge cases.
        read_chk("rd_ctrl", 8'h00, 32'd0);
        read_chk("rd_ff", 8'hFF, 32'd0);
        read_chk("rd_past_end", 8'h0A, 32'd0);
        step('0, 1'b0, 1'b1, 8'h02, 32'hDEAD_BEEF);
        read_chk("ro_write", 8'h02, 32'd1);
        pulse(8'h02, 3);
        ctrl(32'h1, '0);
        step('0, 1'b1, 1'b0, 8'h01, '0);
        check("b2b_ovf", csr_readdata, 32'd0);
        check("b2b_ovf_v", {31'd0, csr_readdatavalid}, 32'd1);
        step('0, 1'b1, 1'b0, 8'h02, '0);
        check("b2b_cnt0", csr_readdata, 32'd1);
        check("b2b_cnt0_v", {31'd0, csr_readdatavalid}, 32'd1);
        step('0, 1'b1, 1'b0, 8'h03, '0);
        check("b2b_cnt1", csr_readdata, 32'd3);
        check("b2b_cnt1_v", {31'd0, csr_readdatavalid}, 32'd1);

        // Async reset between edges with one response showing and one pending.
        pulse(8'hFF, 3);
        csr_read    = 1'b1;
        csr_address = 8'h03;
        @(posedge clk);
        #2;
        check("pre_rst_valid", {31'd0, csr_readdatavalid}, 32'd1);
        check("pre_rst_data", csr_readdata, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, csr_readdatavalid}, 32'd0);
        check("rst_async_data", csr_readdata, 32'd0);
        @(negedge clk);
        csr_read = 1'b0;
        @(negedge clk);
        check("rst_hold_valid", {31'd0, csr_readdatavalid}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_valid", {31'd0, csr_readdatavalid}, 32'd0);
        read_chk("post_rst_shd", 8'h03, 32'd0);
        ctrl(32'h1, '0);
        read_chk("post_rst_ovf", 8'h01, 32'd0);
        for (int n = 0; n < NC; n++) begin
            read_chk($sformatf("post_rst_cnt%0d", n), AW'(2 + n), 32'd0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
